// File: rtl/display_scanner.sv
// display_scanner: time-multiplexed driver for a 4-digit 7-segment display.
// A prescaler sets how long each digit stays lit. New values are double
// buffered and only reach the display at a frame boundary, so a single frame
// never shows digits from two different values. Leading zeros can be blanked.
module display_scanner #(
    parameter int DIV = 50000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] valor,
    input  logic        carregar,
    input  logic        apagar_zeros,
    output logic [3:0]  entrada,
    output logic [3:0]  anodo,
    output logic        frame_fim,
    output logic        pendente
);

    // Counter width; DIV=1 still needs a one-bit counter that never leaves 0.
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

    logic [CW-1:0] cnt_r;
    logic [1:0]    idx_r;
    logic [15:0]   pend_r;
    logic [15:0]   ativo_r;
    logic          pendente_r;
    logic          frame_fim_r;

    logic          tick_s;
    logic          wrap_s;
    logic [3:0]    nibble_s;
    logic          blank_s;
    logic [3:0]    onehot_s;

    // Digit k is a leading zero when it and every digit to its left are 0.
    function automatic logic lead_zero(input logic [15:0] v, input logic [1:0] k);
        logic z;
        case (k)
            2'd0:    z = 1'b0;
            2'd1:    z = (v[15:4]  == 12'h000);
            2'd2:    z = (v[15:8]  == 8'h00);
            2'd3:    z = (v[15:12] == 4'h0);
            default: z = 1'b0;
        endcase
        return z;
    endfunction

    // Dwell tick and end-of-frame tick.
    always_comb begin
        tick_s = (cnt_r == CNT_MAX);
        wrap_s = tick_s && (idx_r == 2'd3);
    end

    // Prescaler: counts 0..DIV-1 and wraps.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_r <= {CW{1'b0}};
        end else if (tick_s) begin
            cnt_r <= {CW{1'b0}};
        end else begin
            cnt_r <= cnt_r + CW'(1'b1);
        end
    end

    // Digit index advances once per dwell period.
    always_ff @(posedge clock) begin
        if (reset) begin
            idx_r <= 2'd0;
        end else if (tick_s) begin
            idx_r <= idx_r + 2'd1;
        end else begin
            idx_r <= idx_r;
        end
    end

    // Double buffer: a load always lands in pend; ativo only moves at a frame wrap.
    always_ff @(posedge clock) begin
        if (reset) begin
            pend_r     <= 16'h0000;
            ativo_r    <= 16'h0000;
            pendente_r <= 1'b0;
        end else begin
            if (wrap_s && pendente_r) begin
                ativo_r <= pend_r;
            end else begin
                ativo_r <= ativo_r;
            end
            if (carregar) begin
                pend_r     <= valor;
                pendente_r <= 1'b1;
            end else if (wrap_s) begin
                pend_r     <= pend_r;
                pendente_r <= 1'b0;
            end else begin
                pend_r     <= pend_r;
                pendente_r <= pendente_r;
            end
        end
    end

    // One-cycle pulse after the last digit of a frame has finished its dwell.
    always_ff @(posedge clock) begin
        if (reset) begin
            frame_fim_r <= 1'b0;
        end else begin
            frame_fim_r <= wrap_s;
        end
    end

    // Select the nibble and anode for the current digit, applying blanking.
    always_comb begin
        nibble_s = 4'h0;
        onehot_s = 4'b1111;
        case (idx_r)
            2'd0: begin
                nibble_s = ativo_r[3:0];
                onehot_s = 4'b1110;
            end
            2'd1: begin
                nibble_s = ativo_r[7:4];
                onehot_s = 4'b1101;
            end
            2'd2: begin
                nibble_s = ativo_r[11:8];
                onehot_s = 4'b1011;
            end
            2'd3: begin
                nibble_s = ativo_r[15:12];
                onehot_s = 4'b0111;
            end
            default: begin
                nibble_s = 4'h0;
                onehot_s = 4'b1111;
            end
        endcase
        blank_s = apagar_zeros && lead_zero(ativo_r, idx_r);
        if (blank_s) begin
            anodo = 4'b1111;
        end else begin
            anodo = onehot_s;
        end
        entrada = nibble_s;
    end

    // Registered status outputs.
    always_comb begin
        pendente  = pendente_r;
        frame_fim = frame_fim_r;
    end

endmodule

// File: tb/tb_display_scanner.sv
// Self-checking bench for display_scanner: a DIV=4 and a DIV=1 instance share
// inputs; a time-based reference model predicts both, plus a constant table
// and hand-written sequences for the multi-cycle corner cases.
module tb_display_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld;
    logic [15:0] val;
    logic        az;

    logic [3:0]  ent4, an4, ent1, an1;
    logic        ff4, pen4, ff1, pen1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    display_scanner #(.DIV(4)) dut4 (
        .clock(clk), .reset(rst), .valor(val), .carregar(ld), .apagar_zeros(az),
        .entrada(ent4), .anodo(an4), .frame_fim(ff4), .pendente(pen4)
    );

    display_scanner #(.DIV(1)) dut1 (
        .clock(clk), .reset(rst), .valor(val), .carregar(ld), .apagar_zeros(az),
        .entrada(ent1), .anodo(an1), .frame_fim(ff1), .pendente(pen1)
    );

    // Reference model state: time since reset plus the two value buffers.
    int          mt[2];
    int          mdiv[2] = '{4, 1};
    logic [15:0] mpend[2];
    logic [15:0] mativo[2];
    logic        mpen[2];
    logic        mff[2];
    logic        az_g = 1'b0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t4=%0d actual=%h expected=%h", name, mt[0], act, exp);
        end
    endtask

    task automatic model_edge(input int i);
        bit tick, wrap;
        if (rst) begin
            mt[i] = 0; mpend[i] = 16'h0; mativo[i] = 16'h0; mpen[i] = 1'b0; mff[i] = 1'b0;
        end else begin
            tick = (mt[i] % mdiv[i]) == (mdiv[i] - 1);
            wrap = tick && (((mt[i] / mdiv[i]) % 4) == 3);
            mff[i] = wrap;
            if (wrap && mpen[i]) mativo[i] = mpend[i];
            if (ld) begin
                mpend[i] = val; mpen[i] = 1'b1;
            end else if (wrap) begin
                mpen[i] = 1'b0;
            end
            mt[i]++;
        end
    endtask

    task automatic model_check(input int i);
        int d;
        logic [15:0] rem;
        logic [3:0] e_ent, e_an, a_ent, a_an;
        logic a_ff, a_pen;
        d = (mt[i] / mdiv[i]) % 4;
        rem = mativo[i] >> (4 * d);
        e_ent = rem[3:0];
        e_an = (az && d != 0 && rem == 16'h0) ? 4'b1111 : ~(4'b0001 << d);
        a_ent = (i == 0) ? ent4 : ent1;
        a_an  = (i == 0) ? an4  : an1;
        a_ff  = (i == 0) ? ff4  : ff1;
        a_pen = (i == 0) ? pen4 : pen1;
        chk($sformatf("model_entrada_div%0d", mdiv[i]), 16'(a_ent), 16'(e_ent));
        chk($sformatf("model_anodo_div%0d", mdiv[i]), 16'(a_an), 16'(e_an));
        chk($sformatf("model_frame_fim_div%0d", mdiv[i]), 16'(a_ff), 16'(mff[i]));
        chk($sformatf("model_pendente_div%0d", mdiv[i]), 16'(a_pen), 16'(mpen[i]));
        chk($sformatf("onehot_div%0d", mdiv[i]), 16'($countones(~a_an) <= 1), 16'h1);
    endtask

    task automatic step(input logic r, input logic l, input logic [15:0] v, input logic a);
        rst = r; ld = l; val = v; az = a;
        @(posedge clk);
        for (int i = 0; i < 2; i++) model_edge(i);
        #1;
        for (int i = 0; i < 2; i++) model_check(i);
    endtask

    task automatic goto(input int target);
        for (int k = 0; k < 4000 && mt[0] != target; k++) step(1'b0, 1'b0, 16'h0, az_g);
        chk("goto_reached", 16'(mt[0]), 16'(target));
    endtask

    typedef struct {
        logic        r;
        logic        l;
        logic [15:0] v;
        logic [3:0]  e_ent;
        logic [3:0]  e_an;
        logic        e_pen;
        logic        e_ff;
    } vec_t;

    vec_t tbl[18];

    initial begin
        rst = 1'b1; ld = 1'b0; val = 16'h0; az = 1'b0;

        // Reset, 16 idle cycles, then a load of 1234 (DIV=4 instance).
        tbl[0]  = '{1'b1, 1'b0, 16'h0000, 4'h0, 4'b1110, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 16'h0000, 4'h0, 4'b1110, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 16'h0000, 4'h0, 4'b1110, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 16'h0000, 4'h0, 4'b1110, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 16'h0000, 4'h0, 4'b1101, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 16'h0000, 4'h0, 4'b1101, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 16'h0000, 4'h0, 4'b1101, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 16'h0000, 4'h0, 4'b1101, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 16'h0000, 4'h0, 4'b1011, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 16'h0000, 4'h0, 4'b1011, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 16'h0000, 4'h0, 4'b1011, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 16'h0000, 4'h0, 4'b1011, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 16'h0000, 4'h0, 4'b0111, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 16'h0000, 4'h0, 4'b0111, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 16'h0000, 4'h0, 4'b0111, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 16'h0000, 4'h0, 4'b0111, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 1'b0, 16'h0000, 4'h0, 4'b1110, 1'b0, 1'b1};
        tbl[17] = '{1'b0, 1'b1, 16'h1234, 4'h0, 4'b1110, 1'b1, 1'b0};

        for (int i = 0; i < 18; i++) begin
            step(tbl[i].r, tbl[i].l, tbl[i].v, 1'b0);
            chk($sformatf("tbl%0d_entrada", i), 16'(ent4), 16'(tbl[i].e_ent));
            chk($sformatf("tbl%0d_anodo", i), 16'(an4), 16'(tbl[i].e_an));
            chk($sformatf("tbl%0d_pendente", i), 16'(pen4), 16'(tbl[i].e_pen));
            chk($sformatf("tbl%0d_frame_fim", i), 16'(ff4), 16'(tbl[i].e_ff));
        end

        // 1234 transfers at the next wrap and shows 4,3,2,1.
        goto(31);
        chk("wait_pendente", 16'(pen4), 16'h1);
        goto(32); chk("ld_d0", 16'(ent4), 16'h4); chk("ld_pend_clear", 16'(pen4), 16'h0);
        goto(36); chk("ld_d1", 16'(ent4), 16'h3);
        goto(40); chk("ld_d2", 16'(ent4), 16'h2);
        goto(44); chk("ld_d3", 16'(ent4), 16'h1);

        // Leading-zero blanking on 00A0.
        az_g = 1'b1;
        step(1'b0, 1'b1, 16'h00A0, az_g);
        goto(64); chk("blank_d0_ent", 16'(ent4), 16'h0); chk("blank_d0_an", 16'(an4), 16'hE);
        goto(68); chk("blank_d1_ent", 16'(ent4), 16'hA); chk("blank_d1_an", 16'(an4), 16'hD);
        goto(72); chk("blank_d2_an", 16'(an4), 16'hF);
        goto(76); chk("blank_d3_an", 16'(an4), 16'hF);
        az_g = 1'b0;
        step(1'b0, 1'b0, 16'h0, az_g);
        chk("noblank_d3_an", 16'(an4), 16'h7);

        // Last write wins; a load on the wrap cycle lands in the next frame.
        goto(80); step(1'b0, 1'b1, 16'h1111, az_g);
        goto(84); step(1'b0, 1'b1, 16'h2222, az_g);
        goto(95); step(1'b0, 1'b1, 16'h3333, az_g);
        chk("wrap_ld_ent", 16'(ent4), 16'h2); chk("wrap_ld_pend", 16'(pen4), 16'h1);
        goto(108); chk("wrap_ld_d3", 16'(ent4), 16'h2);
        goto(112); chk("next_frame_ent", 16'(ent4), 16'h3); chk("next_frame_pend", 16'(pen4), 16'h0);

        // Reset during digit 2 with a pending value, load in the same cycle.
        step(1'b0, 1'b1, 16'h5678, az_g);
        goto(120);
        step(1'b1, 1'b1, 16'h9999, az_g);
        chk("rst_an", 16'(an4), 16'hE); chk("rst_ent", 16'(ent4), 16'h0);
        chk("rst_pend", 16'(pen4), 16'h0); chk("rst_an_div1", 16'(an1), 16'hE);
        step(1'b0, 1'b0, 16'h0, az_g);
        chk("div1_an_t1", 16'(an1), 16'hD); chk("div1_ff_t1", 16'(ff1), 16'h0);
        step(1'b0, 1'b0, 16'h0, az_g);
        chk("div1_an_t2", 16'(an1), 16'hB);
        step(1'b0, 1'b0, 16'h0, az_g);
        chk("div1_an_t3", 16'(an1), 16'h7); chk("div1_ff_t3", 16'(ff1), 16'h0);
        step(1'b0, 1'b0, 16'h0, az_g);
        chk("div1_an_t4", 16'(an1), 16'hE); chk("div1_ff_t4", 16'(ff1), 16'h1);
        goto(32);
        chk("rst_discard_ent", 16'(ent4), 16'h0); chk("rst_discard_pend", 16'(pen4), 16'h0);

        // Randomised traffic against the model.
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/display_scanner.md
DISPLAY_SCANNER -- requirements
Module: display_scanner

Interface
REQ-001 Parameter DIV, default 50000, meaning clock cycles each digit is lit; legal range 1..2^20.
REQ-002 clock  input  1  single system clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 valor  input  16  four hex digits to display; bits [3:0] are digit 0, the rightmost digit.
REQ-005 carregar  input  1  load strobe; samples valor in the same cycle.
REQ-006 apagar_zeros  input  1  leading-zero blanking enable; level-sensitive, sampled every cycle.
REQ-007 entrada  output  4  nibble of the currently selected digit; drives the 7-segment decoder input directly.
REQ-008 anodo  output  4  active-low digit enables, one-hot low; bit i selects digit i.
REQ-009 frame_fim  output  1  one-cycle pulse marking the end of a full 4-digit scan.
REQ-010 pendente  output  1  high while a loaded value is waiting to be displayed.

Function
REQ-011 Prescaler cnt SHALL count 0..DIV-1 and wrap to 0; tick SHALL be asserted in the cycle where cnt==DIV-1.
REQ-012 With DIV=1, tick SHALL be asserted every cycle.
REQ-013 Digit index idx (2 bits) SHALL advance 0->1->2->3->0 on each tick only.
REQ-014 The block SHALL hold two 16-bit registers: pend (pending) and ativo (displayed).
REQ-015 carregar=1 SHALL write valor into pend and set pendente=1 on the next edge.
REQ-016 A second carregar before transfer SHALL overwrite pend (last write wins), with pendente staying 1.
REQ-017 On a tick with idx==3 (frame wrap) and pendente=1, ativo SHALL take pend and pendente SHALL clear on that edge.
REQ-018 If carregar and a frame-wrap tick occur in the same cycle, the new valor SHALL go into pend, pendente SHALL remain 1, and ativo SHALL take the old pend if pendente was 1; otherwise ativo is unchanged.
REQ-019 ativo SHALL never change except at a frame-wrap tick, so no frame mixes two values.
REQ-020 entrada SHALL equal ativo[4*idx+3 : 4*idx], combinationally from registers (zero added latency).
REQ-021 Digit k>0 is blank when apagar_zeros=1 and ativo nibbles k..3 are all 4'h0; digit 0 SHALL never be blank.
REQ-022 anodo SHALL be ~(4'b0001<<idx) when the selected digit is not blank, and 4'b1111 when it is blank.
REQ-023 frame_fim SHALL be a registered pulse, high for exactly the one cycle after a tick with idx==3.
REQ-024 No input combination SHALL drive more than one anodo bit low.

Reset
REQ-025 reset=1 SHALL set cnt=0, idx=0, pend=0, ativo=0, pendente=0 and frame_fim=0; resulting outputs are entrada=4'h0 and anodo=4'b1110.
REQ-026 reset SHALL take priority over carregar and tick in the same cycle.
REQ-027 Reset mid-frame SHALL discard any pending value, with no transfer to ativo.
REQ-028 Scanning SHALL restart at digit 0 with a full DIV-cycle dwell in the first cycle after reset deasserts.

Verification (DIV=4 unless noted)
REQ-029 Reset, then idle for 16 cycles -> anodo sequence 1110, 1101, 1011, 0111, each held 4 cycles, entrada=0 throughout; frame_fim pulses once, in cycle 16.
REQ-030 Load 16'h1234 mid-frame -> pendente=1 until the next wrap; the following frame shows entrada 4, 3, 2, 1 on digits 0..3; pendente then 0.
REQ-031 Load 16'h00A0 with apagar_zeros=1 -> digits 2 and 3 give anodo=1111; digit 1 shows A; digit 0 shows 0 and is lit. With apagar_zeros=0 -> all four digits are lit.
REQ-032 Load 16'h1111, then 16'h2222 before the wrap, then pulse carregar with 16'h3333 on the wrap cycle -> next frame shows 2222, the frame after shows 3333.
REQ-033 Assert reset during digit 2 with pendente=1 -> next cycle anodo=1110, entrada=0, pendente=0; the old pending value never appears.
REQ-034 DIV=1 -> anodo changes every cycle and frame_fim pulses every 4th cycle.
